// File: rtl/xadc_current_sequencer_if.sv
// xadc_current_sequencer_if: XADC DRP read port plus end-of-conversion strobe.
// master = the sequencer driving the DRP, slave = the xadc_wiz side.
interface xadc_current_sequencer_if;
  logic eoc_in, drdy_in, den_out, dwe_out;
  logic [15:0] do_in, di_out;
  logic [6:0] daddr_out;
  modport master(input eoc_in, drdy_in, do_in, output daddr_out, den_out, dwe_out, di_out);
  modport slave(output eoc_in, drdy_in, do_in, input daddr_out, den_out, dwe_out, di_out);
endinterface

// File: rtl/xadc_current_sequencer.sv
// xadc_current_sequencer: alternating VAUX6/VAUX14 DRP reader with latched over-current fault.
// Define CURRENT_FILTER_EN to smooth current_a/current_b with a first-order IIR.
module xadc_current_sequencer #(
  parameter logic [6:0]  ADDR_A       = 7'h16,
  parameter logic [6:0]  ADDR_B       = 7'h1E,
  parameter logic [11:0] OC_THRESH    = 12'd950,
  parameter int          TRIP_COUNT   = 4,
  parameter int          TIMEOUT_CYC  = 64,
  parameter int          FILTER_SHIFT = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  xadc_current_sequencer_if.master        drp,
  input  logic                            fault_clear,
  output logic [11:0]                     current_a,
  output logic [11:0]                     current_b,
  output logic                            valid_a,
  output logic                            valid_b,
  output logic                            overcurrent_out,
  output logic                            timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, STORE} state_t;
  state_t state;
  logic chan_sel, over, store, trip, unused_ok;
  logic [TW-1:0] tmr;
  logic [3:0] cnt_a, cnt_b, cnt_sel, cnt_next;
  logic [11:0] raw, cur_sel, cur_next;
`ifdef CURRENT_FILTER_EN
  logic loaded_a, loaded_b;
  logic signed [12:0] diff;
`endif
  assign drp.dwe_out = 1'b0;
  assign drp.di_out = 16'h0;
  assign unused_ok = ^{drp.do_in[3:0], 32'(FILTER_SHIFT)};
  // The raw code, never the filtered value, feeds the trip comparison.
  always_comb begin
    raw = drp.do_in[15:4];
    store = state == WAIT && drp.drdy_in;
    over = raw >= OC_THRESH;
    cnt_sel = chan_sel ? cnt_b : cnt_a;
    cnt_next = !over ? 4'd0 : (&cnt_sel ? cnt_sel : cnt_sel + 4'd1);
    trip = store && over && cnt_next >= 4'(TRIP_COUNT);
    cur_sel = chan_sel ? current_b : current_a;
`ifdef CURRENT_FILTER_EN
    diff = $signed({1'b0, raw}) - $signed({1'b0, cur_sel});
    cur_next = (chan_sel ? loaded_b : loaded_a) ? cur_sel + 12'(diff >>> FILTER_SHIFT) : raw;
`else
    cur_next = raw;
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      chan_sel <= 1'b0;
      tmr <= '0;
      cnt_a <= 4'd0;
      cnt_b <= 4'd0;
      current_a <= 12'd0;
      current_b <= 12'd0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      overcurrent_out <= 1'b0;
      timeout_err <= 1'b0;
      drp.den_out <= 1'b0;
      drp.daddr_out <= ADDR_A;
`ifdef CURRENT_FILTER_EN
      loaded_a <= 1'b0;
      loaded_b <= 1'b0;
`endif
    end else begin
      drp.den_out <= 1'b0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      case (state)
        IDLE: if (drp.eoc_in) begin
          state <= REQ;
          drp.den_out <= 1'b1;
          drp.daddr_out <= chan_sel ? ADDR_B : ADDR_A;
        end
        REQ: begin
          state <= WAIT;
          tmr <= '0;
        end
        WAIT: if (drp.drdy_in) begin
          state <= STORE;
          chan_sel <= ~chan_sel;
          if (chan_sel) begin
            current_b <= cur_next;
            valid_b <= 1'b1;
            cnt_b <= cnt_next;
          end else begin
            current_a <= cur_next;
            valid_a <= 1'b1;
            cnt_a <= cnt_next;
          end
`ifdef CURRENT_FILTER_EN
          if (chan_sel) loaded_b <= 1'b1;
          else loaded_a <= 1'b1;
`endif
        end else if (tmr == TW'(TIMEOUT_CYC - 1)) begin
          timeout_err <= 1'b1;
          chan_sel <= ~chan_sel;
          state <= IDLE;
        end else tmr <= tmr + 1'b1;
        default: state <= IDLE;
      endcase
      // A clear coinciding with a trip still wipes the counters, but the trip keeps the fault set.
      if (fault_clear) begin
        cnt_a <= 4'd0;
        cnt_b <= 4'd0;
      end
      overcurrent_out <= trip | (overcurrent_out & ~fault_clear);
    end
  end
endmodule

// File: tb/tb_xadc_current_sequencer.sv
// tb_xadc_current_sequencer: table vectors, hand corner sequences and randomized reads
// checked against a sample-level reference model of the sequencer.
module tb_xadc_current_sequencer;
  logic clk = 1'b0, reset = 1'b0, fault_clear = 1'b0;
  logic [11:0] current_a, current_b;
  logic valid_a, valid_b, overcurrent_out, timeout_err;
  int n_chk = 0, n_fail = 0;
  xadc_current_sequencer_if x();
  xadc_current_sequencer dut(
    .clk(clk), .reset(reset), .drp(x), .fault_clear(fault_clear),
    .current_a(current_a), .current_b(current_b), .valid_a(valid_a), .valid_b(valid_b),
    .overcurrent_out(overcurrent_out), .timeout_err(timeout_err));
  always #5 clk = ~clk;

  bit m_chan, m_oc, m_tmo;
  int m_cnt[2];
  logic [11:0] m_cur[2];
  bit m_loaded[2];

  typedef struct {logic [11:0] code; bit clr; bit fc; bit oc;} vec_t;
  vec_t tbl[35];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_chan = 0; m_oc = 0; m_tmo = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_cur[0] = 0; m_cur[1] = 0;
    m_loaded[0] = 0; m_loaded[1] = 0;
  endtask

  function automatic logic [11:0] filt(input logic [11:0] cur, input logic [11:0] raw, input bit loaded);
`ifdef CURRENT_FILTER_EN
    int d;
    if (!loaded) return raw;
    d = int'(raw) - int'(cur);
    return 12'(int'(cur) + (d >>> 2));
`else
    return raw;
`endif
  endfunction

  task automatic m_store(input logic [11:0] code, input bit fc);
    int c;
    bit over, trip;
    c = m_chan ? 1 : 0;
    over = code >= 12'd950;
    m_cnt[c] = over ? (m_cnt[c] < 15 ? m_cnt[c] + 1 : 15) : 0;
    trip = over && m_cnt[c] >= 4;
    if (fc) begin m_cnt[0] = 0; m_cnt[1] = 0; end
    m_oc = trip || (m_oc && !fc);
    m_cur[c] = filt(m_cur[c], code, m_loaded[c]);
    m_loaded[c] = 1;
    m_chan = !m_chan;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_current_a"}, current_a, m_cur[0]);
    chk({tag, "_current_b"}, current_b, m_cur[1]);
    chk({tag, "_overcurrent"}, overcurrent_out, m_oc);
    chk({tag, "_timeout_err"}, timeout_err, m_tmo);
  endtask

  task automatic pulse_clear();
    @(negedge clk) fault_clear = 1;
    @(negedge clk) fault_clear = 0;
    m_oc = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    chk("clear_oc", overcurrent_out, 0);
  endtask

  // One full read: eoc, den check, dly WAIT cycles, drdy carrying code (fc asserted on the drdy cycle).
  task automatic do_read(input logic [11:0] code, input int dly, input bit fc);
    bit c;
    c = m_chan;
    @(negedge clk) x.eoc_in = 1;
    @(negedge clk) x.eoc_in = 0;
    chk("den_pulse", x.den_out, 1);
    chk("daddr", x.daddr_out, c ? 7'h1E : 7'h16);
    repeat (dly) @(negedge clk);
    chk("den_single", x.den_out, 0);
    x.drdy_in = 1; x.do_in = {code, 4'($urandom)}; fault_clear = fc;
    @(negedge clk) x.drdy_in = 0; fault_clear = 0;
    m_store(code, fc);
    chk("valid_a", valid_a, !c);
    chk("valid_b", valid_b, c);
    check_outputs("store");
    @(negedge clk);
    chk("valid_a_drop", valid_a, 0);
    chk("valid_b_drop", valid_b, 0);
  endtask

  initial begin
    bit c;
    logic [11:0] code;
    tbl = '{
      '{12'h123,0,0,0}, '{12'h123,0,0,0}, '{12'h123,0,0,0}, '{12'h123,0,0,0},
      '{12'd960,0,0,0}, '{12'd100,0,0,0}, '{12'd960,0,0,0}, '{12'd100,0,0,0},
      '{12'd960,0,0,0}, '{12'd100,0,0,0}, '{12'd960,0,0,1}, '{12'd100,1,0,0},
      '{12'd960,0,0,0}, '{12'd100,0,0,0}, '{12'd960,0,0,0}, '{12'd100,0,0,0},
      '{12'd960,0,0,0}, '{12'd100,0,0,0}, '{12'd900,0,0,0}, '{12'd100,0,0,0},
      '{12'd960,0,0,0}, '{12'd100,0,0,0}, '{12'd960,0,0,0}, '{12'd100,0,0,0},
      '{12'd960,0,0,0}, '{12'd100,0,0,0}, '{12'd960,0,1,1}, '{12'd100,0,0,1},
      '{12'd960,1,0,0}, '{12'd100,0,0,0}, '{12'd960,0,0,0}, '{12'd100,0,0,0},
      '{12'd960,0,0,0}, '{12'd100,0,0,0}, '{12'd960,0,0,1}};
    x.eoc_in = 0; x.drdy_in = 0; x.do_in = 16'h0;
    m_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    chk("reset_valid", {valid_a, valid_b}, 0);
    chk("reset_den", x.den_out, 0);
    chk("reset_daddr", x.daddr_out, 7'h16);
    chk("dwe_di_tied", {x.dwe_out, x.di_out}, 0);
    reset = 1;

    for (int i = 0; i < 35; i++) begin
      if (tbl[i].clr) pulse_clear();
      do_read(tbl[i].code, 3, tbl[i].fc);
      chk($sformatf("tbl%0d_oc", i), overcurrent_out, tbl[i].oc);
`ifndef CURRENT_FILTER_EN
      chk($sformatf("tbl%0d_cur", i), i % 2 ? current_b : current_a, tbl[i].code);
`endif
    end

    // Withheld drdy: abort after 64 WAIT cycles, no data update, order advances.
    c = m_chan;
    @(negedge clk) x.eoc_in = 1;
    @(negedge clk) x.eoc_in = 0;
    chk("tmo_den", x.den_out, 1);
    chk("tmo_daddr", x.daddr_out, c ? 7'h1E : 7'h16);
    repeat (64) @(negedge clk);
    chk("tmo_early", timeout_err, 0);
    @(negedge clk);
    m_tmo = 1; m_chan = !m_chan;
    check_outputs("tmo");
    chk("tmo_no_valid", {valid_a, valid_b}, 0);
    do_read(12'd321, 2, 0);

    // eoc during WAIT is dropped: no second den during or after the read.
    @(negedge clk) x.eoc_in = 1;
    @(negedge clk) x.eoc_in = 0;
    chk("drop_den", x.den_out, 1);
    @(negedge clk) x.eoc_in = 1;
    @(negedge clk) x.eoc_in = 0;
    chk("drop_no_den0", x.den_out, 0);
    @(negedge clk);
    chk("drop_no_den1", x.den_out, 0);
    c = m_chan;
    x.drdy_in = 1; x.do_in = {12'd777, 4'h5};
    @(negedge clk) x.drdy_in = 0;
    m_store(12'd777, 0);
    chk("drop_valid", c ? valid_b : valid_a, 1);
    check_outputs("drop");
    repeat (3) begin
      @(negedge clk);
      chk("drop_idle_den", x.den_out, 0);
    end

    for (int i = 0; i < 60; i++) begin
      code = $urandom_range(0, 1) ? 12'($urandom_range(930, 1000)) : 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 9) == 0) pulse_clear();
      do_read(code, $urandom_range(1, 20), $urandom_range(0, 7) == 0);
    end

    // Reset in the middle of a read, then a late drdy that must be ignored.
    @(negedge clk) x.eoc_in = 1;
    @(negedge clk) x.eoc_in = 0;
    @(negedge clk);
    @(negedge clk) reset = 0;
    #1;
    m_reset();
    check_outputs("midrst");
    chk("midrst_valid", {valid_a, valid_b}, 0);
    chk("midrst_den", x.den_out, 0);
    chk("midrst_daddr", x.daddr_out, 7'h16);
    @(negedge clk) reset = 1;
    @(negedge clk) x.drdy_in = 1; x.do_in = 16'hABC0;
    @(negedge clk) x.drdy_in = 0;
    chk("late_drdy_valid", {valid_a, valid_b}, 0);
    @(negedge clk);
    chk("late_drdy_valid2", {valid_a, valid_b}, 0);
    check_outputs("late_drdy");
    do_read(12'd0, 3, 0);
    do_read(12'd55, 3, 0);
    do_read(12'd400, 3, 0);
    do_read(12'd55, 3, 0);
    do_read(12'd400, 3, 0);
`ifdef CURRENT_FILTER_EN
    chk("filter_175", current_a, 12'd175);
`else
    chk("raw_400", current_a, 12'd400);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
